// File: rtl/dm_load_store_unit.sv
// Data-memory stage: byte/half/word stores into an on-chip word array and
// synchronous word loads, producing the raw word plus the extender selector.
module dm_load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  memop,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] Dout,
  output logic [3:0]  extop,
  output logic        rvalid,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] badaddr
);

  localparam logic [3:0] OP_LW  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LHU = 4'b0011;
  localparam logic [3:0] OP_LB  = 4'b0100;
  localparam logic [3:0] OP_LBU = 4'b0101;
  localparam logic [3:0] OP_SW  = 4'b0110;
  localparam logic [3:0] OP_SH  = 4'b0111;
  localparam logic [3:0] OP_SB  = 4'b1000;

  // Handshake: req is a valid-only strobe with no back-pressure; every request
  // is accepted in its own cycle and any response/exception appears one cycle later.
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              is_load;
  logic              is_store;
  logic              misaligned;
  logic [3:0]        load_extop;
  logic [3:0]        byte_en;
  logic [31:0]       store_data;

  assign idx = addr[ADDR_W+1:2];

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    load_extop = 4'b0000;
    byte_en    = 4'b0000;
    store_data = wdata;
    unique case (memop)
      OP_LW: begin
        is_load    = 1'b1;
        misaligned = addr[1:0] != 2'b00;
        load_extop = 4'b0001;
      end
      OP_LB: begin
        is_load    = 1'b1;
        load_extop = {2'b01, addr[1:0]} - 4'd2;
      end
      OP_LH: begin
        is_load    = 1'b1;
        misaligned = addr[0];
        load_extop = {3'b011, addr[1]};
      end
      OP_LBU: begin
        is_load    = 1'b1;
        load_extop = {2'b10, addr[1:0]};
      end
      OP_LHU: begin
        is_load    = 1'b1;
        misaligned = addr[0];
        load_extop = {3'b110, addr[1]};
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = addr[1:0] != 2'b00;
        byte_en    = 4'b1111;
      end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = addr[0];
        byte_en    = addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
      end
      OP_SB: begin
        is_store   = 1'b1;
        byte_en    = 4'b0001 << addr[1:0];
        store_data = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Lane data is replicated so each enabled lane simply takes its own byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= 32'h0;
    end else if (req && is_store && !misaligned) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) mem[idx][8*b +: 8] <= store_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Dout     <= 32'h0;
      extop    <= 4'b0000;
      rvalid   <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      badaddr  <= 32'h0;
    end else begin
      rvalid   <= 1'b0;
      extop    <= 4'b0000;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      if (req && is_load && !misaligned) begin
        Dout   <= mem[idx];
        extop  <= load_extop;
        rvalid <= 1'b1;
      end
      if (req && misaligned) begin
        exc_adel <= is_load;
        exc_ades <= is_store;
        badaddr  <= addr;
      end
    end
  end

endmodule

// File: tb/tb_dm_load_store_unit.sv
// Directed bench for dm_load_store_unit: stores, loads, extender selectors,
// misalignment exceptions, address wrap and mid-stream reset.
module tb_dm_load_store_unit;

  localparam logic [3:0] NONE = 4'b0000, LW = 4'b0001, LH = 4'b0010, LHU = 4'b0011,
                         LB = 4'b0100, LBU = 4'b0101, SW = 4'b0110, SH = 4'b0111,
                         SB = 4'b1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [3:0]  memop = NONE;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] Dout;
  logic [3:0]  extop;
  logic        rvalid;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] badaddr;

  int vectors = 0;
  int miscompares = 0;

  dm_load_store_unit #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .req(req), .memop(memop), .addr(addr),
    .wdata(wdata), .Dout(Dout), .extop(extop), .rvalid(rvalid),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .badaddr(badaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one operation, clock it in, and return #1 after the edge.
  task automatic op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] d);
    req   = 1'b1;
    memop = code;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req   = 1'b0;
    memop = NONE;
    @(posedge clk);
    #1;
  endtask

  task automatic load_chk(input string tag, input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] exp_word, input logic [3:0] exp_extop);
    op(code, a, 32'h0);
    check({tag, "_dout"}, Dout, exp_word);
    check({tag, "_extop"}, {28'h0, extop}, {28'h0, exp_extop});
    check({tag, "_rvalid"}, {31'h0, rvalid}, 32'h1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", Dout, 32'h0);
    check("rst_extop", {28'h0, extop}, 32'h0);
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_exc", {30'h0, exc_adel, exc_ades}, 32'h0);
    check("rst_badaddr", badaddr, 32'h0);
    reset = 1'b0;
    idle();

    // Reset while a load response is pending
    op(SW, 32'h10, 32'hDEADBEEF);
    check("sw10_rvalid", {31'h0, rvalid}, 32'h0);
    load_chk("lw10", LW, 32'h10, 32'hDEADBEEF, 4'b0001);
    req = 1'b0;
    memop = NONE;
    #1 reset = 1'b1;
    #1;
    check("midrst_dout", Dout, 32'h0);
    check("midrst_rvalid", {31'h0, rvalid}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    load_chk("lw10_after_rst", LW, 32'h10, 32'h0, 4'b0001);

    // Word store/load and back-to-back byte/half loads
    op(SW, 32'h40, 32'h11223344);
    load_chk("lw40", LW, 32'h40, 32'h11223344, 4'b0001);
    op(SB, 32'h42, 32'h000000AB);
    load_chk("lb42", LB, 32'h42, 32'h11AB3344, 4'b0100);
    load_chk("lbu43", LBU, 32'h43, 32'h11AB3344, 4'b1011);

    op(SH, 32'h46, 32'h0000BEEF);
    load_chk("lhu46", LHU, 32'h46, 32'hBEEF0000, 4'b1101);
    load_chk("lh44", LH, 32'h44, 32'hBEEF0000, 4'b0110);
    idle();
    check("idle_rvalid", {31'h0, rvalid}, 32'h0);
    check("idle_extop", {28'h0, extop}, 32'h0);
    check("idle_dout_hold", Dout, 32'hBEEF0000);

    // Misaligned loads and stores
    op(LW, 32'h41, 32'h0);
    check("adel41", {31'h0, exc_adel}, 32'h1);
    check("adel41_badaddr", badaddr, 32'h41);
    check("adel41_rvalid", {31'h0, rvalid}, 32'h0);
    check("adel41_extop", {28'h0, extop}, 32'h0);
    idle();
    check("adel_pulse", {31'h0, exc_adel}, 32'h0);
    check("badaddr_hold", badaddr, 32'h41);
    op(SH, 32'h45, 32'h00001234);
    check("ades45", {31'h0, exc_ades}, 32'h1);
    check("ades45_badaddr", badaddr, 32'h45);
    check("ades45_adel", {31'h0, exc_adel}, 32'h0);
    load_chk("lw44_unchanged", LW, 32'h44, 32'hBEEF0000, 4'b0001);
    check("ades_pulse", {31'h0, exc_ades}, 32'h0);
    op(SW, 32'h42, 32'hFFFFFFFF);
    check("ades42", {31'h0, exc_ades}, 32'h1);
    op(LH, 32'h43, 32'h0);
    check("adel43_lh", {31'h0, exc_adel}, 32'h1);
    check("adel43_badaddr", badaddr, 32'h43);
    load_chk("lw40_after_bad_sw", LW, 32'h40, 32'h11AB3344, 4'b0001);

    // Address wrap modulo 4 KiB
    op(SW, 32'h1000, 32'hCAFEF00D);
    load_chk("wrap_lw0", LW, 32'h0, 32'hCAFEF00D, 4'b0001);

    // Remaining lanes and selector encodings
    op(SB, 32'h48, 32'h00000077);
    op(SB, 32'h4B, 32'h00000099);
    load_chk("lw48", LW, 32'h48, 32'h99000077, 4'b0001);
    load_chk("lb49", LB, 32'h49, 32'h99000077, 4'b0011);
    load_chk("lb4b", LB, 32'h4B, 32'h99000077, 4'b0101);
    load_chk("lb48", LB, 32'h48, 32'h99000077, 4'b0010);
    load_chk("lbu48", LBU, 32'h48, 32'h99000077, 4'b1000);
    load_chk("lh4a", LH, 32'h4A, 32'h99000077, 4'b0111);
    load_chk("lhu48", LHU, 32'h48, 32'h99000077, 4'b1100);
    op(SH, 32'h48, 32'hAAAA5566);
    load_chk("lw48_sh", LW, 32'h48, 32'h99005566, 4'b0001);

    // Requests that must have no effect
    req = 1'b0; memop = SW; addr = 32'h40; wdata = 32'h0;
    @(posedge clk);
    #1;
    check("noreq_rvalid", {31'h0, rvalid}, 32'h0);
    op(4'b1111, 32'h40, 32'h0);
    check("illegal_rvalid", {31'h0, rvalid}, 32'h0);
    check("illegal_exc", {30'h0, exc_adel, exc_ades}, 32'h0);
    op(4'b1001, 32'h41, 32'h0);
    check("illegal_misal_exc", {30'h0, exc_adel, exc_ades}, 32'h0);
    check("illegal_badaddr", badaddr, 32'h43);
    load_chk("lw40_final", LW, 32'h40, 32'h11AB3344, 4'b0001);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
